// File: rtl/serial_sub6_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub6_pkg;

  localparam int unsigned WIDTH_DEF = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Counter must index bit positions 0..w-1; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_sub6_if.sv
// Start/busy/done handshake and operand/result bus for serial_sub6.
// Optional zero/ovf flags appear when SERIAL_SUB6_FLAGS_EN is defined.
interface serial_sub6_if
  import serial_sub6_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB6_FLAGS_EN
  logic             zero;
  logic             ovf;

  modport master (output start, a, b, bin, input busy, done, diff, bout, zero, ovf);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout, zero, ovf);
`else
  modport master (output start, a, b, bin, input busy, done, diff, bout);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout);
`endif

endinterface

// File: rtl/serial_sub6_fs_cell.sv
// One-bit full subtractor: d = x - y - brw, with the borrow out.
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic brw,
  output logic d_c,
  output logic brw_next_c
);

  assign d_c        = x ^ y ^ brw;
  assign brw_next_c = (~x & y) | (~x & brw) | (y & brw);

endmodule

// File: rtl/serial_sub6.sv
// Bit-serial subtractor diff = a - b - bin, LSB first over WIDTH cycles.
// Define SERIAL_SUB6_FLAGS_EN to add registered zero/ovf result flags.
module serial_sub6
  import serial_sub6_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input logic         clk,
  input logic         rst,
  serial_sub6_if.slave bus
);

  localparam int unsigned    CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state;
  state_e           state_next;
  logic             load_c;
  logic             step_c;
  logic             last_c;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next_c;
  logic [CW-1:0]    cnt;
  logic             brw;
  logic             d_c;
  logic             brw_next_c;
`ifdef SERIAL_SUB6_FLAGS_EN
  logic             a_msb;
  logic             b_msb;
`endif

  fs_cell u_fs_cell (
    .x          (a_sh[0]),
    .y          (b_sh[0]),
    .brw        (brw),
    .d_c        (d_c),
    .brw_next_c (brw_next_c)
  );

  assign res_next_c = {d_c, res_sh[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Start is only honoured from IDLE or DONE; SHIFT runs to completion.
  always_comb begin
    state_next = state;
    load_c     = 1'b0;
    step_c     = 1'b0;
    last_c     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = SHIFT;
          load_c     = 1'b1;
        end
      end
      SHIFT: begin
        step_c = 1'b1;
        if (cnt == CNT_LAST) begin
          last_c     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          state_next = SHIFT;
          load_c     = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.diff <= '0;
      bus.bout <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      cnt      <= '0;
      brw      <= 1'b0;
`ifdef SERIAL_SUB6_FLAGS_EN
      bus.zero <= 1'b0;
      bus.ovf  <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
`endif
    end else begin
      bus.busy <= (state_next == SHIFT);
      bus.done <= (state_next == DONE);
      if (load_c) begin
        a_sh   <= bus.a;
        b_sh   <= bus.b;
        brw    <= bus.bin;
        cnt    <= '0;
        res_sh <= '0;
`ifdef SERIAL_SUB6_FLAGS_EN
        a_msb  <= bus.a[WIDTH-1];
        b_msb  <= bus.b[WIDTH-1];
`endif
      end else if (step_c) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        brw    <= brw_next_c;
        cnt    <= cnt + CW'(1);
        res_sh <= res_next_c;
      end
      // Results only move on the SHIFT->DONE edge and hold otherwise.
      if (last_c) begin
        bus.diff <= res_next_c;
        bus.bout <= brw_next_c;
`ifdef SERIAL_SUB6_FLAGS_EN
        bus.zero <= (res_next_c == '0);
        bus.ovf  <= (a_msb != b_msb) && (d_c != a_msb);
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_sub6.sv
// Scoreboard bench for serial_sub6: directed operations push expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_sub6;
  import serial_sub6_pkg::*;

  localparam int unsigned W = 6;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_sub6_if #(.WIDTH(W)) bus ();

  serial_sub6 #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic launch(input int a, input int b, input int bin,
                        input int ed, input int eb, input int ez, input int eo);
    @(negedge clk);
    bus.a     = W'(a);
    bus.b     = W'(b);
    bus.bin   = 1'(bin);
    bus.start = 1'b1;
    sb_q.push_back('{diff: W'(ed), bout: 1'(eb), zero: 1'(ez), ovf: 1'(eo)});
  endtask

  // Waits for done after a launch, checking latency and busy length.
  task automatic finish_op(input string tag, input bit hold, input int held_diff);
    int lat = -1;
    int bc  = 0;
    bit seen = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (bus.busy) bc++;
      if (bus.done) begin
        seen = 1'b1;
        lat  = c;
      end
      if (hold) begin
        if (c == 3) check({tag, " diff held"}, int'(bus.diff), held_diff);
        if (c <= 5) begin
          bus.start = 1'b1;
          bus.a     = W'($urandom);
          bus.b     = W'($urandom);
          bus.bin   = 1'($urandom);
        end else begin
          bus.start = 1'b0;
        end
      end else if (c == 1) begin
        bus.start = 1'b0;
      end
    end
    check({tag, " done latency"}, lat, W + 1);
    check({tag, " busy cycles"}, bc, W);
  endtask

  always @(negedge clk) begin
    if (bus.done) begin
      if (sb_q.size() == 0) begin
        check("unexpected done", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("diff", int'(bus.diff), int'(mon_e.diff));
        check("bout", int'(bus.bout), int'(mon_e.bout));
`ifdef SERIAL_SUB6_FLAGS_EN
        check("zero", int'(bus.zero), int'(mon_e.zero));
        check("ovf", int'(bus.ovf), int'(mon_e.ovf));
`endif
      end
    end
  end

  initial begin
    int d1;
    int d2;
    int dones;

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    check("reset diff", int'(bus.diff), 0);
    check("reset bout", int'(bus.bout), 0);
`ifdef SERIAL_SUB6_FLAGS_EN
    check("reset zero", int'(bus.zero), 0);
    check("reset ovf", int'(bus.ovf), 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    launch(20, 7, 0, 13, 0, 0, 0);
    finish_op("basic", 1'b0, 0);

    launch(63, 63, 1, 63, 1, 0, 0);
    finish_op("hold", 1'b1, 13);

    launch(5, 9, 0, 60, 1, 0, 0);
    finish_op("underflow", 1'b0, 0);

    launch(0, 0, 1, 63, 1, 0, 0);
    finish_op("borrow in", 1'b0, 0);

    // Back-to-back with start held high across the DONE cycle.
    launch(10, 3, 0, 7, 0, 0, 0);
    sb_q.push_back('{diff: W'(57), bout: 1'b1, zero: 1'b0, ovf: 1'b0});
    d1 = -1;
    d2 = -1;
    for (int c = 1; c <= 30 && d2 < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.a = W'(3);
        bus.b = W'(10);
      end
      if (bus.done) begin
        if (d1 < 0) d1 = c;
        else        d2 = c;
      end else if (d1 >= 0 && c == d1 + 1) begin
        bus.start = 1'b0;
      end
    end
    check("b2b first done", d1, W + 1);
    check("b2b done spacing", (d2 < 0) ? -1 : d2 - d1, W + 1);

    // Reset during the third SHIFT cycle aborts with no done pulse.
    @(negedge clk);
    bus.a     = W'(40);
    bus.b     = W'(1);
    bus.bin   = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort busy", int'(bus.busy), 0);
    check("abort done", int'(bus.done), 0);
    check("abort diff", int'(bus.diff), 0);
    check("abort bout", int'(bus.bout), 0);
    rst = 1'b0;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("abort no done", dones, 0);

    launch(32, 1, 0, 31, 0, 0, 1);
    finish_op("ovf case", 1'b0, 0);

    launch(17, 17, 0, 0, 0, 1, 0);
    finish_op("zero case", 1'b0, 0);

    @(negedge clk);
    check("scoreboard drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
